regfile_reader: RTL and testbench
=================================

// Module: regfile_reader
// PURPOSE
//   Read side of the ARM-style 32-entry register file. Owns the register storage
//   and the write-port address decode, and serves two registered read ports.
//   Sits in the decode stage: operands are requested in cycle N and returned in N+1.
//   X31 (XZR) is hardwired to zero. Same-cycle write data bypasses to the read outputs.
// PARAMETERS
//   WIDTH     64   data width of each register and each read/write data port
//   NUM_REGS  32   register count; the address width is log2(NUM_REGS) = 5
//   ZERO_REG  31   index that always reads 0; writes to it are discarded
// PORTS
//   clk            in   1      rising-edge clock
//   reset_n        in   1      asynchronous active-low reset
//   RegWrite       in   1      write enable
//   WriteRegister  in   5      write index
//   WriteData      in   WIDTH  write data
//   ReadReq1       in   1      port-1 read request
//   ReadRegister1  in   5      port-1 read index
//   ReadReq2       in   1      port-2 read request
//   ReadRegister2  in   5      port-2 read index
//   ReadData1      out  WIDTH  port-1 data, registered
//   ReadValid1     out  1      port-1 data valid, registered
//   ReadData2      out  WIDTH  port-2 data, registered
//   ReadValid2     out  1      port-2 data valid, registered
// BEHAVIOUR
//   - Reset (reset_n=0, async): all NUM_REGS entries are 0. ReadData1/2=0, ReadValid1/2=0.
//     Any write or read in flight is dropped. First valid response comes 1 cycle after
//     the first request sampled with reset_n=1.
//   - Write: on posedge with RegWrite=1 and WriteRegister!=ZERO_REG, the entry
//     [WriteRegister] takes WriteData. When RegWrite=0, no entry changes.
//     A write to ZERO_REG is a no-op.
//   - Read latency 1: on the posedge where ReadReqK=1, ReadValidK<=1 and ReadDataK<=value.
//     When ReadReqK=0, ReadValidK<=0 and ReadDataK holds its previous value.
//   - Value selection per port, in priority order:
//       (1) ReadRegisterK==ZERO_REG -> 0, even when a write to 31 is present.
//       (2) RegWrite=1 and WriteRegister==ReadRegisterK -> WriteData from the same cycle.
//       (3) otherwise the stored entry [ReadRegisterK].
//   - Both ports are independent. The same index on both ports returns identical data,
//     including the bypass case.
//   - No stall or backpressure: a request is accepted every cycle. Back-to-back
//     requests give back-to-back valids.
//   - Indices are always in range (5 bits, 32 entries). No error output.
// TESTING
//   1 reset_n=0 for 2 cycles, then release. Read all 32 indices on both ports
//     -> every ReadData=0, and ReadValid is high exactly 1 cycle after each request.
//   2 Write r[i]=64'hA5A5_0000_0000_0000+i for i=0..30, then read each index
//     -> port returns the written value; read of 31 -> 0.
//   3 Same cycle: RegWrite=1, WriteRegister=7, WriteData=64'hDEAD_BEEF, ReadReq1=1,
//     ReadRegister1=7 -> next cycle ReadData1=64'hDEAD_BEEF (bypass).
//     Old r7 is never visible.
//   4 Write 64'hFFFF_FFFF_FFFF_FFFF to index 31, reading 31 on both ports in the same
//     cycle and the next cycle -> both ports return 0 each time.
//   5 ReadReq1=1 (idx 3), ReadReq2=0, then ReadReq1=0 -> ReadValid1 pulses for 1 cycle.
//     ReadValid2 stays 0. ReadData1 holds r3 after the pulse.
//   6 Write r5=64'h1234, request read of r5, assert reset_n=0 mid-cycle
//     -> outputs clear immediately. After release, a read of r5 returns 0.

Source files
------------

// File: rtl/regfile_reader.sv
// Read side of the 32-entry register file: storage, write decode and two
// registered read ports with same-cycle write bypass and a hardwired zero register.
module regfile_reader #(
  parameter int WIDTH    = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        RegWrite,
  input  logic [$clog2(NUM_REGS)-1:0] WriteRegister,
  input  logic [WIDTH-1:0]            WriteData,
  input  logic                        ReadReq1,
  input  logic [$clog2(NUM_REGS)-1:0] ReadRegister1,
  input  logic                        ReadReq2,
  input  logic [$clog2(NUM_REGS)-1:0] ReadRegister2,
  output logic [WIDTH-1:0]            ReadData1,
  output logic                        ReadValid1,
  output logic [WIDTH-1:0]            ReadData2,
  output logic                        ReadValid2
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] ZeroIdx = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] sel1;
  logic [WIDTH-1:0] sel2;
  logic             writeEn;

  assign writeEn = RegWrite && (WriteRegister != ZeroIdx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Zero register wins over bypass, so a write aimed at it can never leak out.
  always_comb begin
    sel1 = regs[ReadRegister1];
    if (ReadRegister1 == ZeroIdx) begin
      sel1 = '0;
    end else if (RegWrite && (WriteRegister == ReadRegister1)) begin
      sel1 = WriteData;
    end
  end

  always_comb begin
    sel2 = regs[ReadRegister2];
    if (ReadRegister2 == ZeroIdx) begin
      sel2 = '0;
    end else if (RegWrite && (WriteRegister == ReadRegister2)) begin
      sel2 = WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ReadData1  <= '0;
      ReadValid1 <= 1'b0;
      ReadData2  <= '0;
      ReadValid2 <= 1'b0;
    end else begin
      ReadValid1 <= ReadReq1;
      ReadValid2 <= ReadReq2;
      if (ReadReq1) begin
        ReadData1 <= sel1;
      end
      if (ReadReq2) begin
        ReadData2 <= sel2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: reset, write/readback, bypass, zero
// register, valid pulse behaviour and asynchronous reset mid-cycle.
module tb_regfile_reader;

  logic        clk;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic        ReadReq1;
  logic [4:0]  ReadRegister1;
  logic        ReadReq2;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic        ReadValid1;
  logic [63:0] ReadData2;
  logic        ReadValid2;

  int checks = 0;
  int errors = 0;

  regfile_reader #(.WIDTH(64), .NUM_REGS(32), .ZERO_REG(31)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .ReadReq1(ReadReq1),
    .ReadRegister1(ReadRegister1),
    .ReadReq2(ReadReq2),
    .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1),
    .ReadValid1(ReadValid1),
    .ReadData2(ReadData2),
    .ReadValid2(ReadValid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pattern(input int unsigned i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  initial begin
    logic [63:0] exp2;
    int unsigned j;
    reset_n = 1'b0;
    RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadReq1 = 1'b0; ReadRegister1 = '0;
    ReadReq2 = 1'b0; ReadRegister2 = '0;

    // 1: reset, then every index reads zero with one-cycle latency
    step(); step();
    check("rst_data1", ReadData1, 64'd0);
    check("rst_valid1", {63'd0, ReadValid1}, 64'd0);
    check("rst_data2", ReadData2, 64'd0);
    check("rst_valid2", {63'd0, ReadValid2}, 64'd0);
    reset_n = 1'b1;
    step();
    check("idle_valid1", {63'd0, ReadValid1}, 64'd0);
    for (int unsigned i = 0; i < 32; i++) begin
      ReadReq1 = 1'b1; ReadRegister1 = 5'(i);
      ReadReq2 = 1'b1; ReadRegister2 = 5'(31 - i);
      step();
      check("zero_valid1", {63'd0, ReadValid1}, 64'd1);
      check("zero_valid2", {63'd0, ReadValid2}, 64'd1);
      check("zero_data1", ReadData1, 64'd0);
      check("zero_data2", ReadData2, 64'd0);
    end
    ReadReq1 = 1'b0; ReadReq2 = 1'b0;
    step();
    check("zero_end_valid1", {63'd0, ReadValid1}, 64'd0);
    check("zero_end_valid2", {63'd0, ReadValid2}, 64'd0);

    // 2: write r0..r30, read back every index on both ports
    for (int unsigned i = 0; i < 31; i++) begin
      RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = pattern(i);
      step();
    end
    RegWrite = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      j = 31 - i;
      ReadReq1 = 1'b1; ReadRegister1 = 5'(i);
      ReadReq2 = 1'b1; ReadRegister2 = 5'(j);
      step();
      check("wr_data1", ReadData1, (i == 31) ? 64'd0 : pattern(i));
      exp2 = (j == 31) ? 64'd0 : pattern(j);
      check("wr_data2", ReadData2, exp2);
      check("wr_valid1", {63'd0, ReadValid1}, 64'd1);
    end

    // 3: same-cycle write to r7 bypasses onto both ports
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'hDEAD_BEEF;
    ReadReq1 = 1'b1; ReadRegister1 = 5'd7;
    ReadReq2 = 1'b1; ReadRegister2 = 5'd7;
    step();
    check("bypass_data1", ReadData1, 64'hDEAD_BEEF);
    check("bypass_data2", ReadData2, 64'hDEAD_BEEF);
    RegWrite = 1'b0;
    step();
    check("bypass_stored1", ReadData1, 64'hDEAD_BEEF);

    // 4: write all-ones to r31 while reading it; zero both times
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    step();
    check("xzr_same1", ReadData1, 64'd0);
    check("xzr_same2", ReadData2, 64'd0);
    RegWrite = 1'b0;
    step();
    check("xzr_next1", ReadData1, 64'd0);
    check("xzr_next2", ReadData2, 64'd0);
    ReadRegister1 = 5'd30;
    step();
    check("xzr_r30_intact", ReadData1, pattern(30));

    // 5: single-cycle valid pulse, data holds afterwards
    ReadReq1 = 1'b1; ReadRegister1 = 5'd3; ReadReq2 = 1'b0;
    step();
    check("pulse_valid1", {63'd0, ReadValid1}, 64'd1);
    check("pulse_valid2", {63'd0, ReadValid2}, 64'd0);
    check("pulse_data1", ReadData1, pattern(3));
    ReadReq1 = 1'b0; ReadRegister1 = 5'd4;
    step();
    check("pulse_off_valid1", {63'd0, ReadValid1}, 64'd0);
    check("pulse_hold_data1", ReadData1, pattern(3));
    check("pulse_off_valid2", {63'd0, ReadValid2}, 64'd0);
    step();
    check("pulse_hold2_data1", ReadData1, pattern(3));

    // 6: write r5, then reset asynchronously with a read pending
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'h1234;
    step();
    RegWrite = 1'b0;
    ReadReq1 = 1'b1; ReadRegister1 = 5'd5;
    step();
    check("r5_written", ReadData1, 64'h1234);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_data1", ReadData1, 64'd0);
    check("async_valid1", {63'd0, ReadValid1}, 64'd0);
    step();
    #2;
    reset_n = 1'b1;
    step();
    check("post_rst_valid1", {63'd0, ReadValid1}, 64'd1);
    check("post_rst_r5", ReadData1, 64'd0);
    ReadRegister1 = 5'd7;
    step();
    check("post_rst_r7", ReadData1, 64'd0);
    ReadReq1 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
